// File: rtl/formula_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | formula_pkg : shared constants/helpers for formula pipe blocks   |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
package formula_pkg;

  localparam int WIDTH_DEF = 32;

  // Occupancy counters must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/flop_fifo_sync.sv
`default_nettype none
// +------------------------------------------------------------------+
// | flop_fifo_sync : flop-based synchronous FIFO, any DEPTH >= 2     |
// | Revision       : 1.0                                             |
// +------------------------------------------------------------------+
module flop_fifo_sync
  import formula_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [WIDTH-1:0]              wdata,
  input  logic                          pop,
  output logic [WIDTH-1:0]              rdata,
  output logic                          full,
  output logic                          empty,
  output logic [cnt_width(DEPTH)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CNT_W'(DEPTH));
  assign w_pop_ok  = pop && !empty;
  // A pop in the same cycle makes room even when full; when empty the pop is void.
  assign w_push_ok = push && (!full || w_pop_ok);
  assign rdata     = r_mem[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      if (w_push_ok != w_pop_ok) begin
        r_count <= w_push_ok ? r_count + CNT_W'(1) : r_count - CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/formula_pipe_collector.sv
`default_nettype none
// +------------------------------------------------------------------+
// | formula_pipe_collector : credit-gated result FIFO for formula    |
// | pipes (valid-only results in, valid/ready out). Revision 1.0     |
// +------------------------------------------------------------------+
module formula_pipe_collector
  import formula_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          up_vld,
  output logic                          up_ready,
  output logic                          arg_vld,
  input  logic                          res_vld,
  input  logic [WIDTH-1:0]              res,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic                          ovf_err
);

  localparam int CNT_W = cnt_width(DEPTH);

  logic [CNT_W-1:0] r_in_flight;
  logic             r_ovf_err;
  logic [CNT_W:0]   w_used;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;

  flop_fifo_sync #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (res_vld),
    .wdata (res),
    .pop   (out_ready),
    .rdata (out_data),
    .full  (w_full),
    .empty (w_empty),
    .count (count)
  );

  // Credits come from registered state only; issue is blocked while in reset.
  assign w_used    = {1'b0, count} + {1'b0, r_in_flight};
  assign up_ready  = rst && (w_used < (CNT_W + 1)'(DEPTH));
  assign arg_vld   = up_vld && up_ready;
  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;
  assign ovf_err   = r_ovf_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_in_flight <= '0;
    end else if (arg_vld && !res_vld) begin
      r_in_flight <= r_in_flight + CNT_W'(1);
    end else if (!arg_vld && res_vld && (r_in_flight != '0)) begin
      r_in_flight <= r_in_flight - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ovf_err <= 1'b0;
    end else if (res_vld && w_full && !w_pop) begin
      r_ovf_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_formula_pipe_collector.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_formula_pipe_collector : randomized bench with queue model    |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module tb_formula_pipe_collector;
  import formula_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=4 instance
  logic          rst = 1'b0;
  logic          up_vld = 1'b0;
  logic          res_vld = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  res = '0;
  logic          up_ready, arg_vld, out_valid, ovf_err;
  logic [W-1:0]  out_data;
  logic [2:0]    count;

  // DEPTH=5 instance
  logic          up_vld5 = 1'b0;
  logic          res_vld5 = 1'b0;
  logic          out_ready5 = 1'b0;
  logic [W-1:0]  res5 = '0;
  logic          up_ready5, arg_vld5, out_valid5, ovf5;
  logic [W-1:0]  out_data5;
  logic [2:0]    count5;

  formula_pipe_collector #(.WIDTH(W), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .up_vld(up_vld), .up_ready(up_ready), .arg_vld(arg_vld),
    .res_vld(res_vld), .res(res), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .count(count), .ovf_err(ovf_err)
  );

  formula_pipe_collector #(.WIDTH(W), .DEPTH(5)) dut5 (
    .clk(clk), .rst(rst), .up_vld(up_vld5), .up_ready(up_ready5), .arg_vld(arg_vld5),
    .res_vld(res_vld5), .res(res5), .out_valid(out_valid5), .out_ready(out_ready5),
    .out_data(out_data5), .count(count5), .ovf_err(ovf5)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: contents of the buffer, outstanding requests, sticky error.
  logic [W-1:0] mq[$];
  int           m_infl = 0;
  bit           m_ovf = 1'b0;

  // Behavioural formula pipe: fixed-latency delay line.
  bit           pipe_en = 1'b0;
  int           lat = 5;
  bit           pv[8];
  logic [W-1:0] pd[8];
  int           seq = 1;

  int           cyc = 0;
  int           dut_issues = 0;
  int           pops = 0;
  int           first_pop = 0;
  int           last_pop = 0;
  logic         last_up_ready;

  // One clock cycle on the DEPTH=4 instance: check outputs, update model, advance.
  task automatic cycle();
    bit           m_ready, issue, pop;
    logic [W-1:0] tmp;
    if (pipe_en) begin
      res_vld = pv[lat-1];
      res     = pd[lat-1];
    end
    #1;
    m_ready       = rst && ((mq.size() + m_infl) < 4);
    last_up_ready = up_ready;
    if (arg_vld === 1'b1) dut_issues++;
    n_vec++;
    if (up_ready !== m_ready) begin
      n_err++; $display("FAIL up_ready cyc=%0d got=%b exp=%b", cyc, up_ready, m_ready);
    end
    n_vec++;
    if (arg_vld !== (up_vld && m_ready)) begin
      n_err++; $display("FAIL arg_vld cyc=%0d got=%b exp=%b", cyc, arg_vld, up_vld && m_ready);
    end
    n_vec++;
    if (out_valid !== (mq.size() != 0)) begin
      n_err++; $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, mq.size() != 0);
    end
    n_vec++;
    if (count !== 3'(mq.size())) begin
      n_err++; $display("FAIL count cyc=%0d got=%0d exp=%0d", cyc, count, mq.size());
    end
    n_vec++;
    if (ovf_err !== m_ovf) begin
      n_err++; $display("FAIL ovf_err cyc=%0d got=%b exp=%b", cyc, ovf_err, m_ovf);
    end
    if (mq.size() != 0) begin
      n_vec++;
      if (out_data !== mq[0]) begin
        n_err++; $display("FAIL out_data cyc=%0d got=%h exp=%h", cyc, out_data, mq[0]);
      end
    end

    issue = up_vld && m_ready;
    pop   = (mq.size() != 0) && out_ready;
    if (!rst) begin
      mq.delete();
      m_infl = 0;
      m_ovf  = 1'b0;
      for (int i = 0; i < 8; i++) pv[i] = 1'b0;
    end else begin
      if (pop) begin
        tmp = mq.pop_front();
        pops++;
        if (pops == 1) first_pop = cyc;
        last_pop = cyc;
      end
      if (res_vld) begin
        if (mq.size() < 4) mq.push_back(res);
        else m_ovf = 1'b1;
      end
      if (issue && !res_vld) m_infl++;
      else if (!issue && res_vld && m_infl > 0) m_infl--;
      if (pipe_en) begin
        for (int i = 7; i > 0; i--) begin
          pv[i] = pv[i-1];
          pd[i] = pd[i-1];
        end
        pv[0] = issue;
        pd[0] = W'(seq);
        if (issue) seq++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b0; up_vld = 1'b1; res_vld = 1'b1; res = 32'hDEAD_BEEF; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle();
    rst = 1'b1; up_vld = 1'b0; res_vld = 1'b0;
    cycle();
    n_vec++;
    if (last_up_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_up_ready got=%b exp=1", last_up_ready);
    end
  endtask

  task automatic test_credit();
    lat = 5; pipe_en = 1'b1; up_vld = 1'b1; out_ready = 1'b0; dut_issues = 0;
    for (int i = 0; i < 15; i++) cycle();
    n_vec++;
    if (dut_issues != 4) begin
      n_err++; $display("FAIL credit_issues got=%0d exp=4", dut_issues);
    end
    n_vec++;
    if (count !== 3'd4 || up_ready !== 1'b0 || ovf_err !== 1'b0) begin
      n_err++; $display("FAIL credit_full got count=%0d up_ready=%b ovf=%b exp 4/0/0", count, up_ready, ovf_err);
    end
    up_vld = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) cycle();
    pipe_en = 1'b0; res_vld = 1'b0;
  endtask

  task automatic test_stream();
    lat = 1; pipe_en = 1'b1; seq = 1; pops = 0; out_ready = 1'b1;
    for (int i = 0; i < 400 && pops < 100; i++) begin
      up_vld = (seq <= 100);
      cycle();
    end
    up_vld = 1'b0;
    cycle();
    pipe_en = 1'b0; res_vld = 1'b0;
    n_vec++;
    if (pops != 100) begin
      n_err++; $display("FAIL stream_count got=%0d exp=100", pops);
    end
    n_vec++;
    if (last_pop - first_pop != 99) begin
      n_err++; $display("FAIL stream_throughput span got=%0d exp=99", last_pop - first_pop);
    end
  endtask

  task automatic test_full_simul();
    up_vld = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      res_vld = 1'b1; res = $urandom;
      cycle();
    end
    res_vld = 1'b1; res = 32'hAA; out_ready = 1'b1;
    cycle();
    res_vld = 1'b0; out_ready = 1'b0;
    cycle();
    n_vec++;
    if (count !== 3'd4 || ovf_err !== 1'b0) begin
      n_err++; $display("FAIL full_push_pop got count=%0d ovf=%b exp 4/0", count, ovf_err);
    end
    res_vld = 1'b1; res = 32'hAA; out_ready = 1'b0;
    cycle();
    res_vld = 1'b0;
    cycle();
    n_vec++;
    if (ovf_err !== 1'b1 || count !== 3'd4) begin
      n_err++; $display("FAIL full_overflow got ovf=%b count=%0d exp 1/4", ovf_err, count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    rst = 1'b0; out_ready = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
  endtask

  task automatic test_backpressure();
    up_vld = 1'b0; out_ready = 1'b0;
    res_vld = 1'b1; res = 32'h1234;
    cycle();
    for (int i = 0; i < 3; i++) begin
      res = $urandom;
      cycle();
    end
    res_vld = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_vec++;
      if (out_data !== 32'h1234) begin
        n_err++; $display("FAIL hold_head got=%h exp=00001234", out_data);
      end
    end
    out_ready = 1'b1; up_vld = 1'b1;
    cycle();
    n_vec++;
    if (last_up_ready !== 1'b0) begin
      n_err++; $display("FAIL credit_same_cycle got=%b exp=0", last_up_ready);
    end
    out_ready = 1'b0;
    cycle();
    n_vec++;
    if (last_up_ready !== 1'b1) begin
      n_err++; $display("FAIL credit_next_cycle got=%b exp=1", last_up_ready);
    end
    up_vld = 1'b0;
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
  endtask

  task automatic test_wrap();
    logic [W-1:0] q5[$];
    logic [W-1:0] tmp;
    int           pushed;
    bit           pop;
    pushed = 0;
    for (int c = 0; c < 400 && (pushed < 23 || q5.size() != 0); c++) begin
      res_vld5   = (pushed < 23) && (q5.size() < 5) && ($urandom_range(0, 3) != 0);
      res5       = $urandom;
      out_ready5 = 1'($urandom_range(0, 1));
      #1;
      n_vec++;
      if (count5 !== 3'(q5.size()) || count5 > 3'd5) begin
        n_err++; $display("FAIL wrap_count got=%0d exp=%0d", count5, q5.size());
      end
      n_vec++;
      if (out_valid5 !== (q5.size() != 0) || ovf5 !== 1'b0 || arg_vld5 !== 1'b0) begin
        n_err++; $display("FAIL wrap_flags got valid=%b ovf=%b arg=%b exp %b/0/0", out_valid5, ovf5, arg_vld5, q5.size() != 0);
      end
      n_vec++;
      if (up_ready5 !== (q5.size() < 5)) begin
        n_err++; $display("FAIL wrap_up_ready got=%b exp=%b", up_ready5, q5.size() < 5);
      end
      if (q5.size() != 0) begin
        n_vec++;
        if (out_data5 !== q5[0]) begin
          n_err++; $display("FAIL wrap_data got=%h exp=%h", out_data5, q5[0]);
        end
      end
      pop = (q5.size() != 0) && out_ready5;
      if (pop) tmp = q5.pop_front();
      if (res_vld5) begin
        q5.push_back(res5);
        pushed++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    res_vld5 = 1'b0; out_ready5 = 1'b0;
    n_vec++;
    if (pushed != 23 || q5.size() != 0) begin
      n_err++; $display("FAIL wrap_timeout got pushed=%0d left=%0d exp 23/0", pushed, q5.size());
    end
  endtask

  initial begin
    test_reset();
    test_credit();
    test_stream();
    test_full_simul();
    test_backpressure();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
